// File: rtl/cnn_pkg.sv
// Shared definitions for the 8x8 binary CNN front end: image geometry,
// pixel-index width and the frame loader state encoding.
package cnn_pkg;

    localparam int IMG_DIM   = 8;
    localparam int FRAME_PIX = IMG_DIM * IMG_DIM;
    localparam int PIX_IDX_W = $clog2(FRAME_PIX);

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2
    } loader_state_t;

    // True when the index addresses the final pixel of a frame.
    function automatic logic is_last_pix(input logic [PIX_IDX_W-1:0] idx);
        return idx == PIX_IDX_W'(FRAME_PIX - 1);
    endfunction

endpackage

// File: rtl/frame_buffer_bank.sv
// Fill-buffer storage for the frame loader with bit-indexed writes.
// With IMAGE_FRAME_LOADER_PINGPONG_EN defined it holds two banks, a select
// pointer and a completion flag so a shadow frame can fill while the
// classifier is busy; otherwise it is a single 64-bit buffer.
module frame_buffer_bank
    import cnn_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [PIX_IDX_W-1:0] wr_idx,
    input  logic                 wr_bit,
`ifdef IMAGE_FRAME_LOADER_PINGPONG_EN
    input  logic                 swap,
    output logic                 complete,
`endif
    output logic [FRAME_PIX-1:0] rd_data
);

`ifdef IMAGE_FRAME_LOADER_PINGPONG_EN
    logic [1:0][FRAME_PIX-1:0] bank;
    logic                      sel;

    // Write the selected bank; a swap hands the filled bank to the launcher
    // and restarts completion tracking on the other bank.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bank     <= '0;
            sel      <= 1'b0;
            complete <= 1'b0;
        end else begin
            if (wr_en) begin
                bank[sel][wr_idx] <= wr_bit;
            end
            if (swap) begin
                sel      <= ~sel;
                complete <= 1'b0;
            end else if (wr_en && is_last_pix(wr_idx)) begin
                complete <= 1'b1;
            end
        end
    end

    assign rd_data = bank[sel];
`else
    logic [FRAME_PIX-1:0] bank;

    // Single buffer: each accepted pixel lands at its raster bit position.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bank <= '0;
        end else if (wr_en) begin
            bank[wr_idx] <= wr_bit;
        end
    end

    assign rd_data = bank;
`endif

endmodule

// File: rtl/image_frame_loader.sv
// Raster pixel loader for the 8x8 binary CNN classifier. Binarizes each
// accepted pixel, assembles a 64-bit frame, pulses cnn_start with the frame
// on image_out and holds it until a fresh rising edge of cnn_done.
// Optional ping-pong buffering: IMAGE_FRAME_LOADER_PINGPONG_EN.
module image_frame_loader
    import cnn_pkg::*;
#(
    parameter int PIX_W  = 8,
    parameter int THRESH = 128
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PIX_W-1:0]     pix_data,
    input  logic                 pix_valid,
    input  logic                 pix_sof,
    output logic                 pix_ready,
    output logic [FRAME_PIX-1:0] image_out,
    output logic                 cnn_start,
    input  logic                 cnn_done,
    output logic                 frame_err,
    output logic [15:0]          frame_cnt
);

    loader_state_t        state;
    logic [PIX_IDX_W-1:0] pix_cnt;
    logic                 done_q;

    logic                 xfer;
    logic                 pix_bit;
    logic                 miss_err;
    logic                 sof_err;
    logic                 wr_en;
    logic [PIX_IDX_W-1:0] wr_idx;
    logic                 last_pix;
    logic                 done_rise;
    logic                 launch_now;
    logic [FRAME_PIX-1:0] buf_data;
    logic [FRAME_PIX-1:0] launch_frame;
`ifdef IMAGE_FRAME_LOADER_PINGPONG_EN
    logic                 bank_complete;
`endif

    frame_buffer_bank u_bank (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_bit   (pix_bit),
`ifdef IMAGE_FRAME_LOADER_PINGPONG_EN
        .swap     (launch_now),
        .complete (bank_complete),
`endif
        .rd_data  (buf_data)
    );

    // Transfer decode, binarization, framing checks and launch decision.
    always_comb begin
        xfer      = pix_valid & pix_ready;
        pix_bit   = pix_data >= PIX_W'(THRESH);
        miss_err  = xfer && (pix_cnt == '0) && !pix_sof;
        sof_err   = xfer && (pix_cnt != '0) && pix_sof;
        wr_en     = xfer && !miss_err;
        wr_idx    = pix_sof ? '0 : pix_cnt;
        last_pix  = wr_en && is_last_pix(wr_idx);
        done_rise = cnn_done && !done_q;
        launch_frame = buf_data;
        if (wr_en) begin
            launch_frame[wr_idx] = pix_bit;
        end
`ifdef IMAGE_FRAME_LOADER_PINGPONG_EN
        launch_now = ((state == ST_FILL) && last_pix) ||
                     ((state == ST_WAIT) && done_rise && (bank_complete || last_pix));
`else
        launch_now = (state == ST_FILL) && last_pix;
`endif
    end

    // Loader FSM with registered handshake, start pulse, error pulse and frame output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_FILL;
            pix_cnt   <= '0;
            done_q    <= 1'b0;
            pix_ready <= 1'b0;
            cnn_start <= 1'b0;
            frame_err <= 1'b0;
            frame_cnt <= '0;
            image_out <= '0;
        end else begin
            done_q    <= cnn_done;
            cnn_start <= 1'b0;
            frame_err <= miss_err | sof_err;
            if (wr_en) begin
                pix_cnt <= last_pix ? '0 : wr_idx + PIX_IDX_W'(1);
            end
            if (launch_now) begin
                state     <= ST_LAUNCH;
                pix_ready <= 1'b0;
                cnn_start <= 1'b1;
                image_out <= launch_frame;
                frame_cnt <= frame_cnt + 16'd1;
            end else begin
                case (state)
                    ST_FILL: begin
                        pix_ready <= 1'b1;
                    end
                    ST_LAUNCH: begin
                        state <= ST_WAIT;
`ifdef IMAGE_FRAME_LOADER_PINGPONG_EN
                        pix_ready <= 1'b1;
`else
                        pix_ready <= 1'b0;
`endif
                    end
                    ST_WAIT: begin
                        if (done_rise) begin
                            state     <= ST_FILL;
                            pix_ready <= 1'b1;
                        end else begin
`ifdef IMAGE_FRAME_LOADER_PINGPONG_EN
                            pix_ready <= !(bank_complete || last_pix);
`else
                            pix_ready <= 1'b0;
`endif
                        end
                    end
                    default: begin
                        state     <= ST_FILL;
                        pix_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
